// File: rtl/stopwatch_lap_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stopwatch_lap_bank                                                         |
// | MM:SS stopwatch with lap freeze, circular lap memory with recall, long-    |
// | press clear, and a directly driven 4-digit seven-segment display.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stopwatch_lap_bank #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int SCAN_BITS   = 20,
    parameter int LAP_DEPTH   = 4,
    parameter int HOLD_CYCLES = 150_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        lap_btn,
    input  logic        recall_btn,
    output logic [15:0] time_bcd,
    output logic [3:0]  DIGIT,
    output logic [7:0]  DISPLAY,
    output logic [15:0] led
);
    localparam int c_PRE_W  = $clog2(TICK_DIV);
    localparam int c_PTR_W  = $clog2(LAP_DEPTH);
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [c_PRE_W-1:0]  c_PRE_MAX   = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_SAT  = c_HOLD_W'(HOLD_CYCLES);
    localparam logic [3:0]          c_DEPTH     = 4'(LAP_DEPTH);

    logic                 r_start_d;
    logic                 r_lap_d;
    logic                 r_recall_d;
    logic [c_HOLD_W-1:0]  r_hold_cnt;
    logic [c_PRE_W-1:0]   r_presc;
    logic [15:0]          r_time;
    logic                 r_running;
    logic                 r_frozen;
    logic                 r_recall;
    logic                 r_overflow;
    logic [15:0]          r_frozen_val;
    logic [15:0]          r_lap [LAP_DEPTH];
    logic [c_PTR_W-1:0]   r_wp;
    logic [c_PTR_W-1:0]   r_rp;
    logic [3:0]           r_count;
    logic [SCAN_BITS-1:0] r_scan_cnt;
    logic [3:0]           r_digit;
    logic [7:0]           r_display;

    logic        w_start_edge;
    logic        w_lap_edge;
    logic        w_recall_edge;
    logic        w_clear;
    logic        w_do_start;
    logic        w_do_lap;
    logic        w_do_recall;
    logic        w_tick;
    logic        w_wrap;
    logic [15:0] w_time_inc;
    logic [15:0] w_shown;
    logic [1:0]  w_sel;
    logic [3:0]  w_nibble;
    logic [3:0]  w_digit;
    logic [7:0]  w_seg;

    assign w_start_edge  = start_btn  & ~r_start_d;
    assign w_lap_edge    = lap_btn    & ~r_lap_d;
    assign w_recall_edge = recall_btn & ~r_recall_d;

    // Priority clear > start > lap > recall; losers are dropped for the cycle.
    assign w_clear     = lap_btn && (r_hold_cnt == c_HOLD_LAST);
    assign w_do_start  = w_start_edge & ~w_clear;
    assign w_do_lap    = w_lap_edge & ~w_clear & ~w_start_edge;
    assign w_do_recall = w_recall_edge & ~w_clear & ~w_start_edge & ~w_lap_edge;

    assign w_tick = r_running && (r_presc == c_PRE_MAX);
    assign w_wrap = (r_time == 16'h5959);

    always_comb begin
        w_time_inc = r_time;
        if (r_time[3:0] != 4'd9) begin
            w_time_inc[3:0] = r_time[3:0] + 4'd1;
        end else begin
            w_time_inc[3:0] = 4'd0;
            if (r_time[7:4] != 4'd5) begin
                w_time_inc[7:4] = r_time[7:4] + 4'd1;
            end else begin
                w_time_inc[7:4] = 4'd0;
                if (r_time[11:8] != 4'd9) begin
                    w_time_inc[11:8] = r_time[11:8] + 4'd1;
                end else begin
                    w_time_inc[11:8]  = 4'd0;
                    w_time_inc[15:12] = (r_time[15:12] != 4'd5) ? r_time[15:12] + 4'd1 : 4'd0;
                end
            end
        end
    end

    // Delayed copies track the inputs during reset so a held button gives no edge.
    always_ff @(posedge clk) begin
        r_start_d  <= start_btn;
        r_lap_d    <= lap_btn;
        r_recall_d <= recall_btn;
    end

    // The hold counter survives clear so one long press clears only once.
    always_ff @(posedge clk) begin
        if (rst || !lap_btn) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != c_HOLD_SAT) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_presc      <= '0;
            r_time       <= '0;
            r_running    <= 1'b0;
            r_frozen     <= 1'b0;
            r_recall     <= 1'b0;
            r_overflow   <= 1'b0;
            r_frozen_val <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                r_lap[i] <= '0;
            end
        end else begin
            if (w_tick) begin
                r_time <= w_time_inc;
                if (w_wrap) begin
                    r_overflow <= 1'b1;
                end
            end
            if (r_running) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
            if (w_do_start) begin
                r_running <= ~r_running;
                if (r_recall) begin
                    r_recall <= 1'b0;
                    r_frozen <= 1'b0;
                end
            end
            if (w_do_lap) begin
                if (r_frozen) begin
                    r_frozen <= 1'b0;
                end else if (r_running) begin
                    r_lap[r_wp]  <= r_time;
                    r_frozen_val <= r_time;
                    r_frozen     <= 1'b1;
                    r_wp         <= r_wp + 1'b1;
                    if (r_count != c_DEPTH) begin
                        r_count <= r_count + 4'd1;
                    end
                end
            end
            // Stored entries are always indices 0..count-1 or the full ring, so
            // stepping below 0 lands on count-1 in both cases.
            if (w_do_recall && !r_running && (r_count != 4'd0)) begin
                r_recall <= 1'b1;
                if (!r_recall) begin
                    r_rp <= r_wp - 1'b1;
                end else begin
                    r_rp <= (r_rp == '0) ? c_PTR_W'(r_count - 4'd1) : r_rp - 1'b1;
                end
            end
        end
    end

    assign w_shown = r_recall ? r_lap[r_rp] : (r_frozen ? r_frozen_val : r_time);
    assign w_sel   = r_scan_cnt[SCAN_BITS-1 -: 2];

    always_comb begin
        w_digit  = 4'b1110;
        w_nibble = w_shown[3:0];
        case (w_sel)
            2'd0: begin w_digit = 4'b1110; w_nibble = w_shown[3:0];   end
            2'd1: begin w_digit = 4'b1101; w_nibble = w_shown[7:4];   end
            2'd2: begin w_digit = 4'b1011; w_nibble = w_shown[11:8];  end
            default: begin w_digit = 4'b0111; w_nibble = w_shown[15:12]; end
        endcase
    end

    always_comb begin
        w_seg = 8'b11111111;
        case (w_nibble)
            4'd0: w_seg = 8'b00000011;
            4'd1: w_seg = 8'b10011111;
            4'd2: w_seg = 8'b00100101;
            4'd3: w_seg = 8'b00001101;
            4'd4: w_seg = 8'b10011001;
            4'd5: w_seg = 8'b01001001;
            4'd6: w_seg = 8'b01000001;
            4'd7: w_seg = 8'b00011111;
            4'd8: w_seg = 8'b00000001;
            4'd9: w_seg = 8'b00001001;
            default: w_seg = 8'b11111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 4'b1110;
            r_display  <= 8'b00000011;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
            r_digit    <= w_digit;
            r_display  <= w_seg;
        end
    end

    assign time_bcd = r_time;
    assign DIGIT    = r_digit;
    assign DISPLAY  = r_display;
    assign led      = {r_overflow, 3'b000, r_count, 1'b0, 3'(r_rp), 1'b0,
                       r_recall, r_frozen, r_running};

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stopwatch_lap_bank                                                      |
// | Directed stimulus with a queue-based scoreboard for stopwatch_lap_bank.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_stopwatch_lap_bank;
    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        start_btn  = 1'b0;
    logic        lap_btn    = 1'b0;
    logic        recall_btn = 1'b0;
    logic [15:0] time_bcd;
    logic [3:0]  DIGIT;
    logic [7:0]  DISPLAY;
    logic [15:0] led;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    stopwatch_lap_bank #(
        .TICK_DIV    (4),
        .SCAN_BITS   (4),
        .LAP_DEPTH   (4),
        .HOLD_CYCLES (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_btn  (start_btn),
        .lap_btn    (lap_btn),
        .recall_btn (recall_btn),
        .time_bcd   (time_bcd),
        .DIGIT      (DIGIT),
        .DISPLAY    (DISPLAY),
        .led        (led)
    );

    // sel: 0 time_bcd, 1 led, 2 DIGIT, 3 DISPLAY
    task automatic expect_val(input int sel, input logic [15:0] v, input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = q.pop_front();
            case (e.sel)
                0:       act = time_bcd;
                1:       act = led;
                2:       act = {12'h000, DIGIT};
                default: act = {8'h00, DISPLAY};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic pulse(input logic s, input logic l, input logic r);
        start_btn  = s;
        lap_btn    = l;
        recall_btn = r;
        @(posedge clk); #1;
        start_btn  = 1'b0;
        lap_btn    = 1'b0;
        recall_btn = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_time(input logic [15:0] v, input int max, input string name);
        for (int i = 0; i < max; i++) begin
            if (time_bcd == v) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, time_bcd %h never reached %h", name, time_bcd, v);
    endtask

    task automatic wait_digit(input logic [3:0] d, input string name);
        for (int i = 0; i < 20; i++) begin
            if (DIGIT == d) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, DIGIT %b never reached %b", name, DIGIT, d);
    endtask

    logic [15:0] rec_led [5] = '{16'h0404, 16'h0434, 16'h0424, 16'h0414, 16'h0404};
    logic [7:0]  rec_seg [5] = '{8'b01001001, 8'b10011001, 8'b00001101, 8'b00100101, 8'b01001001};

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        expect_val(0, 16'h0000, "rst_time");
        expect_val(1, 16'h0000, "rst_led");
        expect_val(2, 16'h000E, "rst_digit");
        expect_val(3, 16'h0003, "rst_display");

        // One minute of counting
        pulse(1'b1, 1'b0, 1'b0);
        repeat (239) @(posedge clk);
        #1;
        checks++;
        if (time_bcd !== 16'h0100) begin
            errors++;
            $display("FAIL minute_time: got %h expected %h", time_bcd, 16'h0100);
        end
        checks++;
        if (led !== 16'h0001) begin
            errors++;
            $display("FAIL minute_led: got %h expected %h", led, 16'h0001);
        end
        wait_digit(4'b1011, "minute_m0_wait");
        expect_val(3, 16'h009F, "minute_m0_display");

        // 59:59 wrap and sticky overflow
        wait_time(16'h5959, 16000, "wait_5959");
        expect_val(1, 16'h0001, "prewrap_led");
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (time_bcd !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_time: got %h expected %h", time_bcd, 16'h0000);
        end
        checks++;
        if (led !== 16'h8001) begin
            errors++;
            $display("FAIL wrap_led: got %h expected %h", led, 16'h8001);
        end

        // Lap freeze while counting continues
        wait_time(16'h0007, 40, "wait_0007");
        pulse(1'b0, 1'b1, 1'b0);
        expect_val(1, 16'h8103, "lap_frozen_led");
        repeat (10) @(posedge clk);
        #1;
        expect_val(0, 16'h0010, "frozen_time_runs");
        wait_digit(4'b1101, "frozen_s1_wait");
        expect_val(3, 16'h0003, "frozen_s1_display");
        wait_digit(4'b1110, "frozen_s0_wait");
        expect_val(3, 16'h001F, "frozen_s0_display");
        pulse(1'b0, 1'b1, 1'b0);
        expect_val(1, 16'h8101, "unfreeze_led");
        wait_time(16'h0030, 200, "wait_0030");
        wait_digit(4'b1101, "live_s1_wait");
        expect_val(3, 16'h000D, "live_s1_display");

        // Long-press clear, once per hold
        lap_btn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (time_bcd !== 16'h0000) begin
            errors++;
            $display("FAIL clear_time: got %h expected %h", time_bcd, 16'h0000);
        end
        checks++;
        if (led !== 16'h0000) begin
            errors++;
            $display("FAIL clear_led: got %h expected %h", led, 16'h0000);
        end
        start_btn = 1'b1;
        @(posedge clk); #1;
        start_btn = 1'b0;
        @(posedge clk); #1;
        repeat (18) @(posedge clk);
        #1;
        expect_val(0, 16'h0004, "no_second_clear_time");
        expect_val(1, 16'h0001, "no_second_clear_led");
        lap_btn = 1'b0;
        @(posedge clk); #1;
        expect_val(1, 16'h0001, "release_led");
        pulse(1'b1, 1'b1, 1'b0);
        expect_val(1, 16'h0000, "start_beats_lap_led");
        expect_val(0, 16'h0005, "start_beats_lap_time");

        // Five laps into a four-entry ring, then recall
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 5; n++) begin
            wait_time(16'(n), 40, "lap_wait");
            pulse(1'b0, 1'b1, 1'b0);
            pulse(1'b0, 1'b1, 1'b0);
        end
        wait_time(16'h0006, 40, "wait_0006");
        pulse(1'b0, 1'b0, 1'b1);
        expect_val(1, 16'h0401, "recall_ignored_running");
        wait_time(16'h0007, 40, "wait_stop");
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (time_bcd !== 16'h0007) begin
            errors++;
            $display("FAIL stopped_time: got %h expected %h", time_bcd, 16'h0007);
        end
        checks++;
        if (led !== 16'h0400) begin
            errors++;
            $display("FAIL stopped_led: got %h expected %h", led, 16'h0400);
        end
        for (int k = 0; k < 5; k++) begin
            pulse(1'b0, 1'b0, 1'b1);
            expect_val(1, rec_led[k], "recall_led");
            wait_digit(4'b1110, "recall_s0_wait");
            expect_val(3, {8'h00, rec_seg[k]}, "recall_s0_display");
        end
        pulse(1'b1, 1'b0, 1'b0);
        expect_val(1, 16'h0401, "start_leaves_recall");
        pulse(1'b1, 1'b0, 1'b0);
        expect_val(1, 16'h0400, "restop_led");
        pulse(1'b0, 1'b0, 1'b1);
        expect_val(1, 16'h0404, "recall_again_led");

        // Reset mid-recall
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_val(0, 16'h0000, "recall_rst_time");
        expect_val(1, 16'h0000, "recall_rst_led");
        expect_val(2, 16'h000E, "recall_rst_digit");
        expect_val(3, 16'h0003, "recall_rst_display");

        // Reset mid-count clears the prescaler
        pulse(1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        expect_val(0, 16'h0001, "pre_rst_time");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_val(0, 16'h0000, "count_rst_time");
        expect_val(1, 16'h0000, "count_rst_led");
        pulse(1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        expect_val(0, 16'h0000, "presc_zero_early");
        @(posedge clk); #1;
        expect_val(0, 16'h0001, "presc_zero_tick");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
